// File: rtl/serial_parallel.sv
// serial_parallel: receive end of the scanner's serial echo-bitmap link.
// Rebuilds an LSB-first serial frame into a FRAME_BITS-wide word, checks the
// frame length, and reports hit count, first-hit index and a no-frame timeout.
module serial_parallel #(
    parameter int FRAME_BITS = 400,
    parameter int IDX_W      = 9,
    parameter int TIMEOUT    = 480,
    parameter int TO_W       = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_en,
    input  logic                  serial_data,
    output logic [FRAME_BITS-1:0] parallel_data,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [IDX_W-1:0]      hit_cnt,
    output logic [IDX_W-1:0]      first_hit,
    output logic                  frame_lost
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN
    } state_t;

    localparam logic [IDX_W-1:0] NO_HIT    = '1;
    localparam logic [IDX_W-1:0] FRAME_LEN = IDX_W'(FRAME_BITS);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_SAT    = TO_W'(TIMEOUT + 1);

    state_t                  state;
    state_t                  state_next;
    logic [FRAME_BITS-1:0]   sh;
    logic [IDX_W-1:0]        bcnt;
    logic [IDX_W-1:0]        run_hit;
    logic [IDX_W-1:0]        run_first;
    logic [TO_W-1:0]         silence;
    logic [TO_W-1:0]         silence_next;
    logic                    capture;
    logic                    commit;
    logic                    short_err;
    logic                    drain_err;
    logic                    frame_end;

    // State register; reset abandons any partial frame without reporting it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the per-cycle events that drive the datapath.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        commit     = 1'b0;
        short_err  = 1'b0;
        drain_err  = 1'b0;
        case (state)
            IDLE: begin
                if (data_en) begin
                    capture    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (data_en) begin
                    if (bcnt < FRAME_LEN) begin
                        capture = 1'b1;
                    end else begin
                        state_next = DRAIN;
                    end
                end else begin
                    if (bcnt == FRAME_LEN) begin
                        commit = 1'b1;
                    end else begin
                        short_err = 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (!data_en) begin
                    drain_err  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Silence counter update: cleared by a good frame, else counts up and parks at TIMEOUT+1.
    always_comb begin
        frame_end = commit | short_err | drain_err;
        if (commit) begin
            silence_next = '0;
        end else if (silence < TO_SAT) begin
            silence_next = silence + TO_W'(1);
        end else begin
            silence_next = silence;
        end
    end

    // Shift register, running accumulators and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sh            <= '0;
            bcnt          <= '0;
            run_hit       <= '0;
            run_first     <= NO_HIT;
            silence       <= '0;
            parallel_data <= '0;
            frame_valid   <= 1'b0;
            frame_err     <= 1'b0;
            hit_cnt       <= '0;
            first_hit     <= NO_HIT;
            frame_lost    <= 1'b0;
        end else begin
            frame_valid <= commit;
            frame_err   <= short_err | drain_err;
            silence     <= silence_next;
            frame_lost  <= (silence_next >= TO_LIMIT);
            if (capture) begin
                sh      <= {serial_data, sh[FRAME_BITS-1:1]};
                bcnt    <= bcnt + IDX_W'(1);
                run_hit <= run_hit + IDX_W'(serial_data);
                if (serial_data && (run_first == NO_HIT)) begin
                    run_first <= bcnt;
                end
            end
            if (frame_end) begin
                bcnt      <= '0;
                run_hit   <= '0;
                run_first <= NO_HIT;
            end
            if (commit) begin
                parallel_data <= sh;
                hit_cnt       <= run_hit;
                first_hit     <= run_first;
            end
        end
    end

endmodule

// File: tb/tb_serial_parallel.sv
// tb_serial_parallel: table-driven, directed and randomized checks of serial_parallel
// against a frame-level reference model.
module tb_serial_parallel;

    localparam int FB     = 400;
    localparam int IW     = 9;
    localparam int NO_HIT = 511;

    logic          clk;
    logic          rst;
    logic          data_en;
    logic          serial_data;
    logic [FB-1:0] parallel_data;
    logic          frame_valid;
    logic          frame_err;
    logic [IW-1:0] hit_cnt;
    logic [IW-1:0] first_hit;
    logic          frame_lost;

    serial_parallel #(
        .FRAME_BITS(FB),
        .IDX_W(IW),
        .TIMEOUT(480),
        .TO_W(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_en(data_en),
        .serial_data(serial_data),
        .parallel_data(parallel_data),
        .frame_valid(frame_valid),
        .frame_err(frame_err),
        .hit_cnt(hit_cnt),
        .first_hit(first_hit),
        .frame_lost(frame_lost)
    );

    typedef struct {
        int   len;
        int   kind;
        int   pos;
        logic exp_valid;
        int   exp_hit;
        int   exp_first;
    } vec_t;

    int checks = 0;
    int fails  = 0;

    // Reference model state: outputs of the last good frame and expected pulse totals.
    logic [FB-1:0] exp_word;
    int            exp_hit;
    int            exp_first;
    int            exp_valid_cnt = 0;
    int            exp_err_cnt   = 0;

    int seen_valid   = 0;
    int seen_err     = 0;
    int seen_overlap = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampling well after each rising edge.
    always @(posedge clk) begin
        #2;
        if (frame_valid) seen_valid++;
        if (frame_err) seen_err++;
        if (frame_valid && frame_err) seen_overlap++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FB-1:0] makeWord(input int kind, input int pos);
        logic [FB-1:0] w;
        w = '0;
        case (kind)
            1: w = '1;
            2: w[pos] = 1'b1;
            3: begin
                w[pos]    = 1'b1;
                w[FB-1]   = 1'b1;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic int lowestOne(input logic [FB-1:0] w);
        for (int i = 0; i < FB; i++) begin
            if (w[i]) return i;
        end
        return NO_HIT;
    endfunction

    task automatic modelReset();
        exp_word  = '0;
        exp_hit   = 0;
        exp_first = NO_HIT;
    endtask

    task automatic doReset();
        rst         = 1'b0;
        data_en     = 1'b0;
        serial_data = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        modelReset();
    endtask

    // Sends len bits (bits past FB are filler), drops data_en, and stops in the result cycle.
    task automatic applyStimulus(input logic [FB-1:0] w, input int len);
        for (int i = 0; i < len; i++) begin
            data_en     = 1'b1;
            serial_data = (i < FB) ? w[i] : 1'($urandom);
            step();
        end
        data_en     = 1'b0;
        serial_data = 1'b0;
        step();
    endtask

    // One frame through the model and the DUT, with the result-cycle pulse checks.
    task automatic runFrame(input string tag, input logic [FB-1:0] w, input int len);
        logic good;
        good = (len == FB);
        if (good) begin
            exp_word  = w;
            exp_hit   = $countones(w);
            exp_first = lowestOne(w);
            exp_valid_cnt++;
        end else begin
            exp_err_cnt++;
        end
        applyStimulus(w, len);
        checkOutput({tag, "_valid"}, FB'(frame_valid), FB'(good));
        checkOutput({tag, "_err"}, FB'(frame_err), FB'(!good));
        checkOutput({tag, "_word"}, parallel_data, exp_word);
    endtask

    initial begin
        vec_t          vecs[8];
        logic [FB-1:0] w;
        int            len;
        int            density;

        vecs[0] = '{400, 2, 17,  1'b1, 1,   17};
        vecs[1] = '{400, 0, 0,   1'b1, 0,   511};
        vecs[2] = '{400, 1, 0,   1'b1, 400, 0};
        vecs[3] = '{399, 1, 0,   1'b0, 400, 0};
        vecs[4] = '{405, 0, 0,   1'b0, 400, 0};
        vecs[5] = '{400, 3, 5,   1'b1, 2,   5};
        vecs[6] = '{1,   1, 0,   1'b0, 2,   5};
        vecs[7] = '{400, 2, 399, 1'b1, 1,   399};

        doReset();
        checkOutput("reset_word", parallel_data, '0);
        checkOutput("reset_valid", FB'(frame_valid), '0);
        checkOutput("reset_err", FB'(frame_err), '0);
        checkOutput("reset_hit", FB'(hit_cnt), '0);
        checkOutput("reset_first", FB'(first_hit), FB'(NO_HIT));
        checkOutput("reset_lost", FB'(frame_lost), '0);

        // Table of frames, zero or one idle cycle apart.
        for (int i = 0; i < 8; i++) begin
            w = makeWord(vecs[i].kind, vecs[i].pos);
            runFrame($sformatf("vec%0d", i), w, vecs[i].len);
            checkOutput($sformatf("vec%0d_hit", i), FB'(hit_cnt), FB'(vecs[i].exp_hit));
            checkOutput($sformatf("vec%0d_first", i), FB'(first_hit), FB'(vecs[i].exp_first));
            if (i % 2 == 1) step();
        end

        // Timeout: silence after reset, recovery on a good frame, short frame does not help.
        doReset();
        repeat (479) step();
        checkOutput("lost_before_limit", FB'(frame_lost), '0);
        step();
        checkOutput("lost_at_limit", FB'(frame_lost), FB'(1));
        repeat (30) step();
        checkOutput("lost_stays_high", FB'(frame_lost), FB'(1));
        runFrame("to_good", makeWord(2, 100), FB);
        checkOutput("lost_cleared_on_commit", FB'(frame_lost), '0);
        repeat (479) step();
        checkOutput("lost_restart_low", FB'(frame_lost), '0);
        step();
        checkOutput("lost_restart_high", FB'(frame_lost), FB'(1));
        runFrame("to_short", makeWord(1, 0), 100);
        checkOutput("lost_after_short", FB'(frame_lost), FB'(1));

        // Reset in the middle of a frame, then a clean frame.
        for (int i = 0; i < 200; i++) begin
            data_en     = 1'b1;
            serial_data = 1'b1;
            step();
        end
        doReset();
        step();
        checkOutput("midrst_err", FB'(frame_err), '0);
        checkOutput("midrst_hit", FB'(hit_cnt), '0);
        checkOutput("midrst_first", FB'(first_hit), FB'(NO_HIT));
        w = makeWord(2, 250);
        runFrame("midrst_frame", w, FB);
        checkOutput("midrst_frame_hit", FB'(hit_cnt), FB'(1));
        checkOutput("midrst_frame_first", FB'(first_hit), FB'(250));

        // Randomized frames checked against the frame-level model.
        for (int n = 0; n < 30; n++) begin
            density = $urandom_range(0, 50);
            for (int k = 0; k < FB; k++) w[k] = ($urandom_range(0, 99) < density);
            if ($urandom_range(0, 9) < 7) begin
                len = FB;
            end else begin
                case ($urandom_range(0, 4))
                    0: len = 1;
                    1: len = 200;
                    2: len = 399;
                    3: len = 401;
                    default: len = 410;
                endcase
            end
            runFrame($sformatf("rnd%0d", n), w, len);
            checkOutput($sformatf("rnd%0d_hit", n), FB'(hit_cnt), FB'(exp_hit));
            checkOutput($sformatf("rnd%0d_first", n), FB'(first_hit), FB'(exp_first));
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        checkOutput("valid_pulse_total", FB'(seen_valid), FB'(exp_valid_cnt));
        checkOutput("err_pulse_total", FB'(seen_err), FB'(exp_err_cnt));
        checkOutput("valid_err_overlap", FB'(seen_overlap), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/serial_parallel.md
Name: serial_parallel

Overview:
- Receive end of the scanner's serial echo-bitmap link.
- Deserialises the LSB-first bit stream qualified by data_en, which the upstream parallel-to-serial stage produces, back into a FRAME_BITS-wide word.
- Checks frame length, and derives hit count, first-hit index and a no-frame timeout for the distance-computation logic downstream.

Parameters:
FRAME_BITS, 400, bits per frame; data_en is high for exactly this many consecutive cycles per frame
IDX_W, 9, width of bit counter, hit_cnt and first_hit (must hold FRAME_BITS and sentinel 2^IDX_W-1)
TIMEOUT, 480, cycles without a good frame before frame_lost asserts
TO_W, 10, width of the timeout counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active low
data_en  in  1  high while serial_data carries a valid bit; one bit per cycle, no gaps inside a frame
serial_data  in  1  frame bit; first bit received is word bit 0
parallel_data  out  FRAME_BITS  last good frame, held until the next good frame
frame_valid  out  1  one-cycle pulse when parallel_data/hit_cnt/first_hit update
frame_err  out  1  one-cycle pulse on short or long frame
hit_cnt  out  IDX_W  number of 1 bits in the last good frame
first_hit  out  IDX_W  lowest index holding a 1 in the last good frame; 2^IDX_W-1 if none
frame_lost  out  1  high while the silence counter is at or above TIMEOUT

Behaviour:
- Reset:
  - Synchronous: sampled on the clk rising edge while rst=0. Active-low reset on clk; polarity and synchronicity are fixed.
  - All outputs are 0, except first_hit = all ones.
  - Internal shift register, bit counter, running hit count and running first-hit are cleared; state = IDLE; silence counter = 0.
  - Reset mid-frame discards the partial frame silently, with no frame_err.
- Shift:
  - Each captured bit: sh <= {serial_data, sh[FRAME_BITS-1:1]}. After FRAME_BITS bits, sh[0] is the first bit received.
  - Running hit count increments when serial_data=1.
  - Running first-hit loads the current bit index (0-based) on the first 1 seen in the frame.
- States:
  - IDLE: data_en=1 -> capture the bit as index 0, bcnt=1, go to SHIFT. data_en=0 -> stay.
  - SHIFT:
    - data_en=1 and bcnt<FRAME_BITS -> capture the bit, bcnt+1.
    - data_en=1 and bcnt==FRAME_BITS -> overrun; go to DRAIN without capturing.
    - data_en=0 and bcnt==FRAME_BITS -> commit: parallel_data<=sh, hit_cnt and first_hit <= running values, frame_valid=1 next cycle; go to IDLE.
    - data_en=0 and bcnt<FRAME_BITS -> short frame: frame_err=1 next cycle, outputs unchanged; go to IDLE.
  - DRAIN: hold while data_en=1. data_en=0 -> frame_err=1 next cycle; go to IDLE.
  - Running accumulators clear whenever IDLE is entered.
- Latency: frame_valid is high in the cycle after the first data_en=0 sample that follows the last bit. That is 2 clk edges after the last bit edge.
- Back-to-back frames: a single idle cycle between frames is sufficient. A frame starting in the cycle frame_valid is high is received normally.
- Timeout:
  - Silence counter (TO_W bits) resets to 0 on the commit edge.
  - Otherwise it increments until TIMEOUT, then saturates at TIMEOUT+1.
  - frame_lost = (counter >= TIMEOUT), registered.
  - A bad frame does not reset the counter.
- frame_valid and frame_err are never high in the same cycle.

Test Plan:
1. Reset, then 400 bits with only bit 17 = 1, then data_en low -> frame_valid pulse 2 edges after the last bit; parallel_data = 1<<17; hit_cnt=1; first_hit=17; frame_err=0.
2. All-zero frame -> frame_valid; hit_cnt=0; first_hit=511; parallel_data=0. Then an all-ones frame after one idle cycle -> hit_cnt=400, first_hit=0.
3. data_en high for 399 cycles -> frame_err pulse once; parallel_data, hit_cnt and first_hit keep their prior values; no frame_valid.
4. data_en high for 405 cycles -> DRAIN entered; one frame_err pulse after data_en falls; previous outputs retained; the next 400-bit frame is received correctly.
5. No frames after reset -> frame_lost rises after 480 cycles and stays high. A good frame drops frame_lost on the cycle after the commit, and the counter restarts. A short frame leaves frame_lost high.
6. rst=0 asserted at bit 200 of a frame, released, then a full frame sent -> no frame_err; the new frame is decoded exactly, with no residue from the aborted bits.
